mem_block_mover: RTL and testbench

Sequencing engine that sits directly upstream of the simple dual-port block RAM. It drives the RAM's read address, consumes its registered read data and drives the RAM's write port. On one start command it copies `count` words from `src_addr` onward to `dst_addr` onward. Typical uses are moving frame/line buffers or CPU data blocks between RAM regions without CPU load/store traffic.

---
 rtl/mem_block_mover_if.sv | 46 ++++
 rtl/mem_block_mover.sv | 119 +++++++++++
 tb/tb_mem_block_mover.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_block_mover_if.sv
// mem_block_mover_if: command, status and RAM-port bundle between a controller and mem_block_mover
// Ports/signals:
//   command (controller -> mover): start, abort, src_addr, dst_addr, count
//   status  (mover -> controller): busy, done
//   RAM read port : ram_addr_r (mover -> RAM), ram_data_out (RAM -> mover, 1-cycle registered)
//   RAM write port: ram_addr_w, ram_data_in, ram_we (mover -> RAM)
//   fill_mode, fill_data (controller -> mover): only when MEM_MOVER_FILL_EN is defined
// Modports: master = controller/RAM side, slave = the mover engine.
interface mem_block_mover_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic [ADDR_WIDTH-1:0] ram_addr_w;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram_we;
`ifdef MEM_MOVER_FILL_EN
    logic                  fill_mode;
    logic [DATA_WIDTH-1:0] fill_data;
    modport master (
        output start, abort, src_addr, dst_addr, count, ram_data_out, fill_mode, fill_data,
        input  busy, done, ram_addr_r, ram_addr_w, ram_data_in, ram_we
    );
    modport slave (
        input  start, abort, src_addr, dst_addr, count, ram_data_out, fill_mode, fill_data,
        output busy, done, ram_addr_r, ram_addr_w, ram_data_in, ram_we
    );
`else
    modport master (
        output start, abort, src_addr, dst_addr, count, ram_data_out,
        input  busy, done, ram_addr_r, ram_addr_w, ram_data_in, ram_we
    );
    modport slave (
        input  start, abort, src_addr, dst_addr, count, ram_data_out,
        output busy, done, ram_addr_r, ram_addr_w, ram_data_in, ram_we
    );
`endif
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover: copies count words from src_addr to dst_addr through a simple dual-port block RAM
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, all outputs and counters to 0
//   bus   : mem_block_mover_if.slave (command/status handshake plus RAM read and write ports)
// Optional feature: define MEM_MOVER_FILL_EN to add fill_mode/fill_data, which write a constant
// word instead of the read data while keeping the copy-mode address sequence and timing.
module mem_block_mover #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    mem_block_mover_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_left;
    logic [ADDR_WIDTH-1:0] r_addr_r;
    logic [ADDR_WIDTH-1:0] r_addr_w;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  r_drain;
    logic                  r_v1;
    logic                  r_v2;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_we;

`ifdef MEM_MOVER_FILL_EN
    logic                  r_fill_mode;
    logic [DATA_WIDTH-1:0] r_fill_data;
    assign w_wdata = r_fill_mode ? r_fill_data : bus.ram_data_out;
`else
    assign w_wdata = bus.ram_data_out;
`endif

    // r_v1: ram_addr_r carries a valid read this cycle; r_v2: ram_data_out carries that word.
    // r_left counts reads still to issue after the one launched on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_left    <= '0;
            r_addr_r  <= '0;
            r_addr_w  <= '0;
            r_wptr    <= '0;
            r_data_in <= '0;
            r_drain   <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_we      <= 1'b0;
`ifdef MEM_MOVER_FILL_EN
            r_fill_mode <= 1'b0;
            r_fill_data <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_v2   <= r_v1;
            r_we   <= r_v2;
            if (r_v2) begin
                r_addr_w  <= r_wptr;
                r_data_in <= w_wdata;
                r_wptr    <= r_wptr + 1'b1;
            end
            if (r_state == IDLE) begin
                if (bus.start && bus.count == '0) begin
                    r_done <= 1'b1;
                end else if (bus.start) begin
                    r_state  <= RUN;
                    r_busy   <= 1'b1;
                    r_addr_r <= bus.src_addr;
                    r_wptr   <= bus.dst_addr;
                    r_left   <= bus.count - 1'b1;
                    r_v1     <= 1'b1;
`ifdef MEM_MOVER_FILL_EN
                    r_fill_mode <= bus.fill_mode;
                    r_fill_data <= bus.fill_data;
`endif
                end
            end else if (bus.abort) begin
                // in-flight words are dropped by clearing the whole valid pipeline
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_drain <= 1'b0;
                r_v1    <= 1'b0;
                r_v2    <= 1'b0;
                r_we    <= 1'b0;
            end else if (r_state == RUN) begin
                if (r_left != '0) begin
                    r_addr_r <= r_addr_r + 1'b1;
                    r_left   <= r_left - 1'b1;
                end else begin
                    r_state <= DRAIN;
                    r_v1    <= 1'b0;
                    r_drain <= 1'b0;
                end
            end else if (r_drain) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_drain <= 1'b0;
            end else begin
                r_drain <= 1'b1;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.ram_addr_r  = r_addr_r;
    assign bus.ram_addr_w  = r_addr_w;
    assign bus.ram_data_in = r_data_in;
    assign bus.ram_we      = r_we;
endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: bench with a RAM model, a timeline model of the mover and directed commands
module tb_mem_block_mover;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_block_mover_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mem_block_mover #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem  [0:DEPTH-1];
    logic [DW-1:0] snap [0:DEPTH-1];

    always @(posedge clk) begin
        bus.ram_data_out <= mem[bus.ram_addr_r];
        if (bus.ram_we) mem[bus.ram_addr_w] <= bus.ram_data_in;
    end

    // Timeline model: m_n is the number of edges since the accept edge.
    bit            m_act;
    bit            m_fill;
    int            m_n;
    int            m_cnt;
    logic [AW-1:0] m_src;
    logic [AW-1:0] m_dst;
    logic [DW-1:0] m_fd;
    logic          e_busy;
    logic          e_done;
    logic          e_we;
    logic [AW-1:0] e_addr_r;
    logic [AW-1:0] e_addr_w;
    logic [DW-1:0] e_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 0; e_busy = 0; e_done = 0; e_we = 0;
            e_addr_r = '0; e_addr_w = '0; e_data = '0;
        end else begin
            e_done = 0;
            e_we = 0;
            if (!m_act) begin
                if (bus.start && bus.count == '0) e_done = 1;
                else if (bus.start) begin
                    m_act = 1; m_n = 0; m_cnt = int'(bus.count);
                    m_src = bus.src_addr; m_dst = bus.dst_addr;
                    snap = mem;
                    e_busy = 1; e_addr_r = m_src;
`ifdef MEM_MOVER_FILL_EN
                    m_fill = bus.fill_mode; m_fd = bus.fill_data;
`else
                    m_fill = 0; m_fd = '0;
`endif
                end
            end else begin
                m_n++;
                if (bus.abort || m_n == m_cnt + 2) begin
                    m_act = 0; e_busy = 0; e_done = 1;
                end else begin
                    e_addr_r = m_src + AW'(m_n < m_cnt ? m_n : m_cnt - 1);
                    if (m_n >= 2 && m_n <= m_cnt + 1) begin
                        e_we = 1;
                        e_addr_w = m_dst + AW'(m_n - 2);
                        e_data = m_fill ? m_fd : snap[m_src + AW'(m_n - 2)];
                    end
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("ram_we", 32'(bus.ram_we), 32'(e_we));
        chk("ram_addr_r", 32'(bus.ram_addr_r), 32'(e_addr_r));
        if (e_we) begin
            chk("ram_addr_w", 32'(bus.ram_addr_w), 32'(e_addr_w));
            chk("ram_data_in", 32'(bus.ram_data_in), 32'(e_data));
        end
    endtask

    // Issue one command from a negedge; returns at the negedge where done is seen.
    task automatic cmd(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] c,
                       input int ab, input bit rp, input int exp_w, input int exp_b, input int exp_d);
        int w = 0;
        int b = 0;
        int dn = -1;
        bus.src_addr = s; bus.dst_addr = d; bus.count = c; bus.start = 1'b1;
        for (int n = 0; n < 300 && dn < 0; n++) begin
            tick();
            bus.start = rp && n == 1;
            if (rp && n == 1) bus.src_addr = '0;
            bus.abort = ab > 0 && n == ab - 1;
            if (bus.busy) b++;
            if (bus.ram_we) w++;
            if (bus.done) dn = n;
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("done_cycle", dn, exp_d);
        chk("busy_cycles", b, exp_b);
        chk("write_count", w, exp_w);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.count = '0;
`ifdef MEM_MOVER_FILL_EN
        bus.fill_mode = 1'b0; bus.fill_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i * 7 + 3);
        for (int i = 0; i < 4; i++) mem[16 + i] <= DW'(8'hA0 + i);
        mem[12'hFFE] <= 8'h11; mem[12'hFFF] <= 8'h22; mem[12'h000] <= 8'h33; mem[12'h001] <= 8'h44;
        #1 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        cmd(12'h010, 12'h200, 13'd4, 0, 0, 4, 6, 6);
        for (int i = 0; i < 4; i++) chk("copy_mem", 32'(mem[12'h200 + i]), 32'h0A0 + i);

        cmd(12'hFFE, 12'h7FF, 13'd4, 0, 0, 4, 6, 6);
        chk("wrap_7ff", 32'(mem[12'h7FF]), 32'h11);
        chk("wrap_800", 32'(mem[12'h800]), 32'h22);
        chk("wrap_801", 32'(mem[12'h801]), 32'h33);
        chk("wrap_802", 32'(mem[12'h802]), 32'h44);

        cmd(12'h300, 12'h400, 13'd0, 0, 0, 0, 0, 0);

        cmd(12'h010, 12'h500, 13'd10, 3, 0, 1, 3, 3);
        chk("abort_word0", 32'(mem[12'h500]), 32'hA0);
        chk("abort_word1", 32'(mem[12'h501]), 32'(8'(32'h501 * 7 + 3)));
        cmd(12'h010, 12'h600, 13'd2, 0, 0, 2, 4, 4);
        chk("after_abort_mem", 32'(mem[12'h601]), 32'hA1);

        cmd(12'h010, 12'h700, 13'd4, 0, 1, 4, 6, 6);
        for (int i = 0; i < 4; i++) chk("restart_mem", 32'(mem[12'h700 + i]), 32'h0A0 + i);

        bus.src_addr = 12'h010; bus.dst_addr = 12'h900; bus.count = 13'd10; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_we", 32'(bus.ram_we), 0);
        chk("rst_addr_r", 32'(bus.ram_addr_r), 0);
        chk("rst_addr_w", 32'(bus.ram_addr_w), 0);
        chk("rst_data_in", 32'(bus.ram_data_in), 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        cmd(12'h010, 12'hA00, 13'd4, 0, 0, 4, 6, 6);
        for (int i = 0; i < 4; i++) chk("post_rst_mem", 32'(mem[12'hA00 + i]), 32'h0A0 + i);

`ifdef MEM_MOVER_FILL_EN
        bus.fill_mode = 1'b1; bus.fill_data = 8'h5A;
        cmd(12'h010, 12'h100, 13'd3, 0, 0, 3, 5, 5);
        bus.fill_mode = 1'b0;
        for (int i = 0; i < 3; i++) chk("fill_mem", 32'(mem[12'h100 + i]), 32'h5A);
`endif
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
